// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - shared types and constants for the SPART bus interface
package spart_pkg;

   // Processor-visible register map
   typedef enum logic [1:0] {
      ADDR_DATA   = 2'b00,
      ADDR_STATUS = 2'b01,
      ADDR_DBL    = 2'b10,
      ADDR_DBH    = 2'b11
   } ioaddr_e;

   // Transmit launch sequencer
   typedef enum logic [1:0] {
      TX_IDLE   = 2'b00,
      TX_LAUNCH = 2'b01,
      TX_WAIT   = 2'b10
   } tx_state_e;

   // Status register bit positions
   localparam int ST_RDA     = 0;
   localparam int ST_TBR     = 1;
   localparam int ST_RX_OVF  = 2;
   localparam int ST_TX_OVF  = 3;
   localparam int ST_CNT_LSB = 4;
   localparam int ST_CNT_W   = 4;

   // Clamp a FIFO occupancy to the 4-bit status field
   function automatic logic [ST_CNT_W-1:0] sat_count(input logic [31:0] cnt);
      sat_count = (cnt > 32'd15) ? 4'hF : cnt[ST_CNT_W-1:0];
   endfunction

endpackage

// File: rtl/spart_sync_fifo.sv
// rtl/spart_sync_fifo.sv - synchronous show-ahead FIFO with extra-MSB pointers
module spart_sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             din,
   input  logic                     pop,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic          push_en;
   logic          pop_en;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count = wr_ptr_q - rd_ptr_q;
   assign dout  = mem_q[rd_ptr_q[AW-1:0]];

   // An empty FIFO never pops, so a same-cycle push always lands; a full FIFO takes a push only alongside a pop
   always_comb begin
      pop_en   = pop && !empty;
      push_en  = push && (!full || pop_en);
      wr_ptr_d = push_en ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
      rd_ptr_d = pop_en  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
   end

   // Pointer registers; reset discards contents by equalising the pointers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array, written at the tail slot
   always_ff @(posedge clk) begin
      if (push_en) begin
         mem_q[wr_ptr_q[AW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/spart_bus_fifo_if.sv
// rtl/spart_bus_fifo_if.sv - buffered SPART bus interface, irq logic enabled by SPART_IRQ_EN
module spart_bus_fifo_if
   import spart_pkg::*;
#(
   parameter int                    DATA_W    = 8,
   parameter int                    RX_DEPTH  = 8,
   parameter int                    TX_DEPTH  = 8,
   parameter logic [2*DATA_W-1:0]   DIV_RESET = 'h028B
) (
   input  logic                  clk,
   input  logic                  rst,
   inout  wire  [DATA_W-1:0]     databus,
   input  logic [1:0]            ioaddr,
   input  logic                  iocs,
   input  logic                  iorw,
   input  logic                  rx_valid,
   input  logic [DATA_W-1:0]     rx_data,
   input  logic                  tx_ready,
   output logic                  tx_start,
   output logic [DATA_W-1:0]     tx_data,
   output logic [2*DATA_W-1:0]   baud_div,
   output logic                  baud_load,
   output logic                  irq
);

   localparam int RX_CW = $clog2(RX_DEPTH) + 1;
   localparam int TX_CW = $clog2(TX_DEPTH) + 1;

   ioaddr_e             addr;
   logic                rd_acc, wr_acc;
   logic [DATA_W-1:0]   rd_data;
   logic [DATA_W-1:0]   status;

   logic                rx_pop, rx_full, rx_empty;
   logic [DATA_W-1:0]   rx_head;
   logic [RX_CW-1:0]    rx_count;

   logic                tx_push, tx_pop, tx_full, tx_empty;
   logic [DATA_W-1:0]   tx_head;
   logic [TX_CW-1:0]    tx_count;

   logic                rx_ovf_q, rx_ovf_d;
   logic                tx_ovf_q, tx_ovf_d;
   logic [DATA_W-1:0]   dbl_q, dbl_d;
   logic [2*DATA_W-1:0] baud_div_q, baud_div_d;
   logic                baud_load_q, baud_load_d;

   tx_state_e           state_q;
   logic                tx_start_q;
   logic [DATA_W-1:0]   tx_data_q;

   assign addr   = ioaddr_e'(ioaddr);
   assign rd_acc = iocs && iorw;
   assign wr_acc = iocs && !iorw;

   assign rx_pop  = rd_acc && (addr == ADDR_DATA) && !rx_empty;
   assign tx_push = wr_acc && (addr == ADDR_DATA);
   assign tx_pop  = (state_q == TX_IDLE) && !tx_empty && tx_ready;

   spart_sync_fifo #(.W(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rx_valid),
      .din   (rx_data),
      .pop   (rx_pop),
      .dout  (rx_head),
      .full  (rx_full),
      .empty (rx_empty),
      .count (rx_count)
   );

   spart_sync_fifo #(.W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_push),
      .din   (databus),
      .pop   (tx_pop),
      .dout  (tx_head),
      .full  (tx_full),
      .empty (tx_empty),
      .count (tx_count)
   );

   // Status word assembled from live FIFO state and the sticky overflow flags
   always_comb begin
      status                           = '0;
      status[ST_RDA]                   = !rx_empty;
      status[ST_TBR]                   = !tx_full;
      status[ST_RX_OVF]                = rx_ovf_q;
      status[ST_TX_OVF]                = tx_ovf_q;
      status[ST_CNT_LSB +: ST_CNT_W]   = sat_count(32'(rx_count));
   end

   // Same-cycle read mux; an empty RX reads back as zero
   always_comb begin
      rd_data = '0;
      case (addr)
         ADDR_DATA:   rd_data = rx_empty ? '0 : rx_head;
         ADDR_STATUS: rd_data = status;
         ADDR_DBL:    rd_data = baud_div_q[DATA_W-1:0];
         ADDR_DBH:    rd_data = baud_div_q[2*DATA_W-1:DATA_W];
         default:     rd_data = '0;
      endcase
   end

   assign databus = rd_acc ? rd_data : {DATA_W{1'bz}};

   // Sticky flags clear on a status read, but a new overflow in that cycle wins
   always_comb begin
      rx_ovf_d = rx_ovf_q;
      tx_ovf_d = tx_ovf_q;
      if (rd_acc && (addr == ADDR_STATUS)) begin
         rx_ovf_d = 1'b0;
         tx_ovf_d = 1'b0;
      end
      if (rx_valid && rx_full && !rx_pop) begin
         rx_ovf_d = 1'b1;
      end
      if (tx_push && tx_full && !tx_pop) begin
         tx_ovf_d = 1'b1;
      end
   end

   // Divisor: DBL is only a shadow until DBH commits the full word
   always_comb begin
      dbl_d       = dbl_q;
      baud_div_d  = baud_div_q;
      baud_load_d = 1'b0;
      if (wr_acc && (addr == ADDR_DBL)) begin
         dbl_d = databus;
      end
      if (wr_acc && (addr == ADDR_DBH)) begin
         baud_div_d  = {databus, dbl_q};
         baud_load_d = 1'b1;
      end
   end

   // Register update for sticky flags and divisor state
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_ovf_q    <= 1'b0;
         tx_ovf_q    <= 1'b0;
         dbl_q       <= '0;
         baud_div_q  <= DIV_RESET;
         baud_load_q <= 1'b0;
      end else begin
         rx_ovf_q    <= rx_ovf_d;
         tx_ovf_q    <= tx_ovf_d;
         dbl_q       <= dbl_d;
         baud_div_q  <= baud_div_d;
         baud_load_q <= baud_load_d;
      end
   end

   // Launch sequencer: one pulse per character, re-armed only after the transmitter drops tx_ready
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= TX_IDLE;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         case (state_q)
            TX_IDLE: begin
               if (!tx_empty && tx_ready) begin
                  state_q    <= TX_LAUNCH;
                  tx_start_q <= 1'b1;
                  tx_data_q  <= tx_head;
               end
            end
            TX_LAUNCH: begin
               state_q    <= TX_WAIT;
               tx_start_q <= 1'b0;
            end
            TX_WAIT: begin
               if (!tx_ready) begin
                  state_q <= TX_IDLE;
               end
            end
            default: begin
               state_q    <= TX_IDLE;
               tx_start_q <= 1'b0;
            end
         endcase
      end
   end

   assign tx_start  = tx_start_q;
   assign tx_data   = tx_data_q;
   assign baud_div  = baud_div_q;
   assign baud_load = baud_load_q;

`ifdef SPART_IRQ_EN
   logic irq_q, irq_d;

   // Interrupt on receive data, receive overflow, or transmitter fully drained
   always_comb begin
      irq_d = !rx_empty || rx_ovf_q || (tx_empty && (state_q == TX_IDLE));
   end

   // Registered interrupt output
   always_ff @(posedge clk) begin
      if (rst) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= irq_d;
      end
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_spart_bus_fifo_if.sv
// tb/tb_spart_bus_fifo_if.sv - directed self-checking bench for spart_bus_fifo_if
module tb_spart_bus_fifo_if;

   logic        clk;
   logic        rst;
   wire  [7:0]  databus;
   logic [1:0]  ioaddr;
   logic        iocs;
   logic        iorw;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        tx_ready;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic [15:0] baud_div;
   logic        baud_load;
   logic        irq;

   logic        drv_en;
   logic [7:0]  drv_val;

   int          n_chk;
   int          n_pass;

   assign databus = drv_en ? drv_val : 8'bzzzz_zzzz;

   spart_bus_fifo_if dut (
      .clk       (clk),
      .rst       (rst),
      .databus   (databus),
      .ioaddr    (ioaddr),
      .iocs      (iocs),
      .iorw      (iorw),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .tx_ready  (tx_ready),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .baud_div  (baud_div),
      .baud_load (baud_load),
      .irq       (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
      @(negedge clk);
      iocs   = 1'b1;
      iorw   = 1'b1;
      ioaddr = a;
      #1;
      d = databus;
      @(posedge clk);
      #1;
      iocs = 1'b0;
      iorw = 1'b0;
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      iocs    = 1'b1;
      iorw    = 1'b0;
      ioaddr  = a;
      drv_en  = 1'b1;
      drv_val = d;
      @(posedge clk);
      #1;
      iocs   = 1'b0;
      drv_en = 1'b0;
   endtask

   task automatic rx_push(input logic [7:0] d);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = d;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   logic [7:0] rd;
   int         pulses;
   logic       seen;
   logic [7:0] seen_data;

   initial begin
      n_chk    = 0;
      n_pass   = 0;
      rst      = 1'b1;
      iocs     = 1'b0;
      iorw     = 1'b0;
      ioaddr   = 2'b00;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      tx_ready = 1'b0;
      drv_en   = 1'b0;
      drv_val  = 8'h00;

      // 1. reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_tx_start", 32'(tx_start), 32'h0);
      check("rst_tx_data", 32'(tx_data), 32'h00);
      check("rst_baud_div", 32'(baud_div), 32'h028B);
      check("rst_baud_load", 32'(baud_load), 32'h0);
      bus_rd(2'b01, rd); check("rst_status", 32'(rd), 32'h02);
      bus_rd(2'b10, rd); check("rst_dbl", 32'(rd), 32'h8B);
      bus_rd(2'b11, rd); check("rst_dbh", 32'(rd), 32'h02);

      // 2. two received characters, show-ahead reads, empty read
      rx_push(8'hA5);
      rx_push(8'h3C);
      bus_rd(2'b01, rd); check("rx2_status", 32'(rd), 32'h23);
      bus_rd(2'b00, rd); check("rx2_read0", 32'(rd), 32'hA5);
      bus_rd(2'b00, rd); check("rx2_read1", 32'(rd), 32'h3C);
      bus_rd(2'b00, rd); check("rx2_read_empty", 32'(rd), 32'h00);
      bus_rd(2'b01, rd); check("rx2_status_empty", 32'(rd), 32'h02);

      // 3. RX overflow: nine pushes into eight entries
      for (int i = 0; i < 9; i++) rx_push(8'(i));
      bus_rd(2'b01, rd); check("rxovf_status", 32'(rd), 32'h87);
      bus_rd(2'b01, rd); check("rxovf_cleared", 32'(rd), 32'h83);
      bus_rd(2'b00, rd); check("rxovf_first", 32'(rd), 32'h00);
      for (int i = 1; i < 7; i++) bus_rd(2'b00, rd);
      bus_rd(2'b00, rd); check("rxovf_last", 32'(rd), 32'h07);
      bus_rd(2'b01, rd); check("rxovf_drained", 32'(rd), 32'h02);

      // 4. TX launch and double-launch protection
      tx_ready = 1'b1;
      bus_wr(2'b00, 8'h55);
      check("tx_no_early_start", 32'(tx_start), 32'h0);
      bus_wr(2'b00, 8'h66);
      check("tx_start_pulse", 32'(tx_start), 32'h1);
      check("tx_data_55", 32'(tx_data), 32'h55);
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         if (tx_start) pulses++;
      end
      check("tx_no_double_launch", 32'(pulses), 32'h0);
      @(negedge clk);
      tx_ready = 1'b0;
      @(negedge clk);
      tx_ready = 1'b1;
      seen      = 1'b0;
      seen_data = 8'h00;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         if (tx_start && !seen) begin
            seen      = 1'b1;
            seen_data = tx_data;
         end
      end
      check("tx2_seen", 32'(seen), 32'h1);
      check("tx2_data", 32'(seen_data), 32'h66);

      // 5. divisor shadow and commit
      bus_wr(2'b10, 8'h10);
      check("dbl_only_div", 32'(baud_div), 32'h028B);
      check("dbl_only_load", 32'(baud_load), 32'h0);
      bus_wr(2'b11, 8'h00);
      check("dbh_load_pulse", 32'(baud_load), 32'h1);
      check("dbh_div", 32'(baud_div), 32'h0010);
      @(posedge clk);
      #1;
      check("dbh_load_done", 32'(baud_load), 32'h0);
      bus_wr(2'b10, 8'h77);
      check("dbl_again_div", 32'(baud_div), 32'h0010);
      bus_rd(2'b10, rd); check("dbl_read", 32'(rd), 32'h10);

      // 6. TX overflow, then reset during a launch
      @(negedge clk);
      tx_ready = 1'b0;
      for (int i = 0; i < 8; i++) bus_wr(2'b00, 8'(8'h11 + i));
      bus_rd(2'b01, rd); check("tx_full_status", 32'(rd), 32'h00);
      bus_wr(2'b00, 8'hEE);
      bus_rd(2'b01, rd); check("txovf_status", 32'(rd), 32'h08);
      bus_rd(2'b01, rd); check("txovf_cleared", 32'(rd), 32'h00);
      @(negedge clk);
      tx_ready = 1'b1;
      @(posedge clk);
      #1;
      check("launch_before_rst", 32'(tx_start), 32'h1);
      check("launch_data", 32'(tx_data), 32'h11);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_kills_start", 32'(tx_start), 32'h0);
      bus_rd(2'b01, rd); check("rst_mid_status", 32'(rd), 32'h02);
      @(negedge clk);
      rst = 1'b0;
      bus_rd(2'b10, rd); check("rst_mid_dbl", 32'(rd), 32'h8B);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
